order_risk_gate: RTL and testbench
==================================

# order_risk_gate

Pre-trade risk gate sitting directly upstream of the client-limit memory (`dm_mem_upstream`). It queues incoming order and limit-change requests, reads the client's packed {max, accumulated} word, and decides accept or reject. It issues the accumulate or set-max write over the memory's level-held `rw` / `written` handshake and returns one result per request. At most one memory transaction is in flight.

## Interface
- `IDX_W`, 7: client index width; valid indices are 0..121.
- `FIFO_DEPTH`, 4: request queue depth, power of two.
- `WR_TIMEOUT`, 15: cycles to wait for `mem_written` before giving up.

- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: request present.
- `in_ready` out 1: queue not full.
- `in_client` in `IDX_W`: client index.
- `in_qty` in 16: order quantity, or new max when `in_set_max` is high.
- `in_set_max` in 1: request is a limit change.
- `mem_rdindex` out `IDX_W`: memory index, registered.
- `mem_rddata` in 32: memory word; [31:16] is max, [15:0] is accumulated.
- `mem_rw` out 1: write request level.
- `mem_wdata` out 32: write word.
- `mem_change_max` out 1: high during set-max writes.
- `mem_written` in 1: write-complete level from memory.
- `res_valid` out 1: result present.
- `res_ready` in 1: result consumed.
- `res_accepted` out 1: 1 means accepted.
- `res_reason` out 2: `RSN_OK`, `RSN_LIMIT`, `RSN_BADREQ`, `RSN_TIMEOUT`.
- `res_client` out `IDX_W`: echoed client index.
- `res_headroom` out 16: max − new accumulated (accepted order); max − accumulated (rejected); 0 otherwise.

## Operation
- The request is pushed on `in_valid && in_ready`. The FSM pops the request when in IDLE and the queue is non-empty.
- FSM states: IDLE → READ → CHECK → {WRITE → RELEASE | RESP} → RESP → IDLE.
- **READ**: `mem_rdindex` is set to the client index. The `mem_rddata` sample is captured at the end of READ.
- **CHECK**, in priority order:
  - Client > 121 → `RSN_BADREQ`.
  - Set-max with qty < 2 → `RSN_BADREQ`. This value is not encodable downstream.
  - Set-max otherwise → WRITE with `mem_wdata`={qty,16'h0} and `mem_change_max`=1.
  - Order with qty = 0 → accepted with no write.
  - Order: sum = 17-bit zero-extended acc + qty. If sum ≤ max → WRITE with `mem_wdata`={16'h0,qty}; otherwise `RSN_LIMIT`.
- **WRITE**: `mem_rw`=1 and `mem_wdata` are held stable.
  - When `mem_written` is seen as 1 (after at least one cycle in WRITE), go to RELEASE.
  - After `WR_TIMEOUT` cycles without it, go to RELEASE with `RSN_TIMEOUT` and `res_accepted`=0.
- **RELEASE**: `mem_rw`=0 for exactly one cycle, then go to RESP.
- **RESP**: `res_*` are held until `res_ready`, then go to IDLE.
- The FSM never pops the queue while in a non-IDLE state.

## Timing
- Reset values:
  - `in_ready`=1
  - `mem_rw`=0, `mem_change_max`=0, `mem_wdata`=0, `mem_rdindex`=0
  - `res_valid`=0, `res_accepted`=0, `res_reason`=`RSN_OK`, `res_client`=0, `res_headroom`=0
  - FSM in IDLE, queue empty.
- Push to pop latency is at least 1 cycle.
- Latency with no write: pop to `res_valid` is 3 cycles (READ, CHECK, RESP entry).
- Latency with a write is 3 + W + 1 cycles, where W is the time spent in WRITE (3 with the current memory model).
- Full queue: `in_ready`=0, and a push attempted while full is ignored. A simultaneous push and pop while full is permitted.
- Queue indices wrap modulo `FIFO_DEPTH`.
- Reset mid-operation:
  - `mem_rw` drops immediately.
  - Queue contents and the in-flight request are discarded.
  - No result is issued for them.
- `mem_written` already high at WRITE entry (stale from a previous write) is ignored for the first WRITE cycle.

## Structure
- Package `risk_gate_pkg` holds:
  - the reason enum;
  - a packed `risk_req_t` {client, qty, set_max};
  - constants `CLIENT_MAX`=121 and `MAX_ENC_MIN`=2.
- One sub-module, `risk_req_fifo`: a synchronous FIFO of `risk_req_t` with async reset and full/empty flags.
- The FSM and arithmetic live in `order_risk_gate`.

## Test plan
- **Order within limit**: client 5 has max 0x0100, acc 0x0010; order qty 0x0020.
  - Write issued with wdata 0x00000020.
  - `res_accepted`=1, `res_headroom`=0x00D0.
- **Order over limit**: client 5 has max 0x0100, acc 0x00F0; order qty 0x0020.
  - No `mem_rw` edge.
  - `RSN_LIMIT`, `res_headroom`=0x0010.
- **Set-max**: client 7, qty 0x0200.
  - wdata 0x02000000 and `mem_change_max`=1.
  - Accepted.
- **Bad set-max and bad client**: set-max with qty 1, and order for client 122 → both `RSN_BADREQ` with no memory write.
- **Backpressure**: five back-to-back pushes with `res_ready`=0.
  - `in_ready` falls after the 4th push beyond the popped entry.
  - All five results arrive in order.
- **Timeout and reset**: hold `mem_written`=0 → `RSN_TIMEOUT` after 15 cycles.
  - Assert `rst` during a second WRITE → `mem_rw`=0 at once and no result is issued.

Source files
------------

// File: rtl/risk_gate_pkg.sv
// risk_gate_pkg: shared request, reason and state types for the pre-trade risk gate
package risk_gate_pkg;
   localparam int CLIENT_W    = 7;
   localparam int CLIENT_MAX  = 121;
   localparam int MAX_ENC_MIN = 2;
   typedef enum logic [1:0] {RSN_OK, RSN_LIMIT, RSN_BADREQ, RSN_TIMEOUT} reason_t;
   typedef struct packed {
      logic [CLIENT_W-1:0] client;
      logic [15:0]         qty;
      logic                set_max;
   } risk_req_t;
   typedef enum logic [2:0] {S_IDLE, S_READ, S_CHECK, S_WRITE, S_RELEASE, S_RESP} state_t;
endpackage

// File: rtl/risk_req_fifo.sv
// risk_req_fifo: request queue; accepts a push while full when a pop frees a slot the same cycle
module risk_req_fifo
   import risk_gate_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  logic      pop,
   input  risk_req_t wdata,
   output risk_req_t rdata,
   output logic      full,
   output logic      empty
);
   localparam int AW = $clog2(DEPTH);
   risk_req_t   mem [DEPTH];
   logic [AW:0] wp, rp;
   logic        do_push, do_pop;
   assign empty   = wp == rp;
   assign full    = wp == {~rp[AW], rp[AW-1:0]};
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rp[AW-1:0]];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
      end
   always_ff @(posedge clk)
      if (do_push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/order_risk_gate.sv
// order_risk_gate: queues order/limit requests, checks them against the client's
// {max, accumulated} word and drives one memory write per accepted change.
module order_risk_gate
   import risk_gate_pkg::*;
#(
   parameter int IDX_W      = CLIENT_W,
   parameter int FIFO_DEPTH = 4,
   parameter int WR_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] in_client,
   input  logic [15:0]      in_qty,
   input  logic             in_set_max,
   output logic [IDX_W-1:0] mem_rdindex,
   input  logic [31:0]      mem_rddata,
   output logic             mem_rw,
   output logic [31:0]      mem_wdata,
   output logic             mem_change_max,
   input  logic             mem_written,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_accepted,
   output logic [1:0]       res_reason,
   output logic [IDX_W-1:0] res_client,
   output logic [15:0]      res_headroom
);
   localparam int CW = $clog2(WR_TIMEOUT + 1);
   state_t        state, nxt;
   risk_req_t     req_in, head, cur;
   logic [31:0]   rd;
   logic [CW-1:0] cnt;
   logic          full, empty, pop, bad, over, wr, wr_done, tmo;
   logic [15:0]   mx, acc;
   logic [16:0]   sum;
   assign req_in   = '{client: in_client, qty: in_qty, set_max: in_set_max};
   assign pop      = state == S_IDLE && !empty;
   assign in_ready = !full || pop;
   risk_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(in_valid && in_ready), .pop(pop),
      .wdata(req_in), .rdata(head), .full(full), .empty(empty)
   );
   assign mx      = rd[31:16];
   assign acc     = rd[15:0];
   assign sum     = {1'b0, acc} + {1'b0, cur.qty};
   assign bad     = cur.client > CLIENT_W'(CLIENT_MAX) || (cur.set_max && cur.qty < 16'(MAX_ENC_MIN));
   assign over    = !cur.set_max && cur.qty != '0 && sum > {1'b0, mx};
   assign wr      = !bad && !over && (cur.set_max || cur.qty != '0);
   // a written level left over from the previous write is ignored in the first WRITE cycle
   assign wr_done = cnt != '0 && mem_written;
   assign tmo     = cnt == CW'(WR_TIMEOUT - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= S_IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:    nxt = pop ? S_READ : S_IDLE;
         S_READ:    nxt = S_CHECK;
         S_CHECK:   nxt = wr ? S_WRITE : S_RESP;
         S_WRITE:   nxt = wr_done || tmo ? S_RELEASE : S_WRITE;
         S_RELEASE: nxt = S_RESP;
         S_RESP:    nxt = res_ready ? S_IDLE : S_RESP;
         default:   nxt = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cur            <= '0;
         rd             <= '0;
         cnt            <= '0;
         mem_rdindex    <= '0;
         mem_rw         <= 1'b0;
         mem_wdata      <= '0;
         mem_change_max <= 1'b0;
         res_valid      <= 1'b0;
         res_accepted   <= 1'b0;
         res_reason     <= RSN_OK;
         res_client     <= '0;
         res_headroom   <= '0;
      end else begin
         res_valid <= nxt == S_RESP;
         if (pop) begin
            cur         <= head;
            mem_rdindex <= head.client;
         end
         if (state == S_READ) rd <= mem_rddata;
         if (state == S_CHECK) begin
            cnt            <= '0;
            mem_rw         <= wr;
            mem_change_max <= wr && cur.set_max;
            if (wr) mem_wdata <= cur.set_max ? {cur.qty, 16'h0} : {16'h0, cur.qty};
            res_accepted   <= !bad && !over;
            res_reason     <= bad ? RSN_BADREQ : over ? RSN_LIMIT : RSN_OK;
            res_client     <= cur.client;
            res_headroom   <= bad || cur.set_max ? 16'h0 : over ? mx - acc : mx - sum[15:0];
         end
         if (state == S_WRITE) begin
            cnt <= cnt + 1'b1;
            if (wr_done || tmo) begin
               mem_rw         <= 1'b0;
               mem_change_max <= 1'b0;
            end
            if (!wr_done && tmo) begin
               res_accepted <= 1'b0;
               res_reason   <= RSN_TIMEOUT;
               res_headroom <= 16'h0;
            end
         end
      end
endmodule

// File: tb/tb_order_risk_gate.sv
// tb_order_risk_gate: table vectors, corner sequences and randomized requests against a
// rule-level reference model and a behavioural client-limit memory.
module tb_order_risk_gate;
   import risk_gate_pkg::*;
   typedef struct {
      logic [6:0]  c;
      logic [15:0] q;
      logic        sm;
      logic        acc;
      logic [1:0]  rsn;
      logic [15:0] hd;
      logic        wr;
   } vec_t;
   logic        clk = 0, rst = 1, in_valid = 0, in_set_max = 0, res_ready = 0, mem_written;
   logic        in_ready, mem_rw, mem_change_max, res_valid, res_accepted;
   logic [6:0]  in_client = 0, mem_rdindex, res_client;
   logic [15:0] in_qty = 0, res_headroom;
   logic [31:0] mem_rddata, mem_wdata;
   logic [1:0]  res_reason;
   int          vectors = 0, miscompares = 0;
   bit          hold = 0, stale = 0;
   bit   [15:0] mmax [128], macc [128];
   int          rmax [128], racc [128];
   int          rw_rises = 0, wcnt = 0;
   logic        rw_q = 0, apply_now;
   logic [31:0] last_wdata = 0;
   logic        last_cm = 0;
   vec_t        tbl [19];
   vec_t        bq [5];
   always #5 clk = ~clk;
   order_risk_gate dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_client(in_client),
      .in_qty(in_qty), .in_set_max(in_set_max), .mem_rdindex(mem_rdindex), .mem_rddata(mem_rddata),
      .mem_rw(mem_rw), .mem_wdata(mem_wdata), .mem_change_max(mem_change_max),
      .mem_written(mem_written), .res_valid(res_valid), .res_ready(res_ready),
      .res_accepted(res_accepted), .res_reason(res_reason), .res_client(res_client),
      .res_headroom(res_headroom)
   );
   // memory: combinational read, write completes two cycles after rw rises unless held off
   assign mem_rddata = {mmax[mem_rdindex], macc[mem_rdindex]};
   assign apply_now  = stale ? mem_rw && !rw_q : mem_rw && !mem_written && !hold && wcnt == 1;
   always @(posedge clk or posedge rst)
      if (rst) begin
         mem_written <= 0;
         wcnt        <= 0;
         rw_q        <= 0;
      end else begin
         rw_q <= mem_rw;
         if (mem_rw && !rw_q) begin
            rw_rises   <= rw_rises + 1;
            last_wdata <= mem_wdata;
            last_cm    <= mem_change_max;
         end
         if (apply_now) begin
            if (mem_change_max) mmax[mem_rdindex] <= mem_wdata[31:16];
            else macc[mem_rdindex] <= macc[mem_rdindex] + mem_wdata[15:0];
         end
         if (stale) mem_written <= 1;
         else if (!mem_rw) begin
            mem_written <= 0;
            wcnt        <= 0;
         end else if (!mem_written && !hold) begin
            if (wcnt == 1) mem_written <= 1;
            else wcnt <= wcnt + 1;
         end
      end
   function automatic void model(input logic [6:0] c, input logic [15:0] q, input logic sm,
                                 output logic acc, output logic [1:0] rsn, output logic [15:0] hd,
                                 output logic wr);
      acc = 0; rsn = RSN_OK; hd = 0; wr = 0;
      if (c > 121 || (sm && q < 2)) rsn = RSN_BADREQ;
      else if (sm) begin
         acc = 1; wr = 1; rmax[c] = int'(q);
      end else if (q == 0) begin
         acc = 1; hd = 16'(rmax[c] - racc[c]);
      end else if (racc[c] + int'(q) <= rmax[c]) begin
         acc = 1; wr = 1; racc[c] = racc[c] + int'(q); hd = 16'(rmax[c] - racc[c]);
      end else begin
         rsn = RSN_LIMIT; hd = 16'(rmax[c] - racc[c]);
      end
   endfunction
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic check_res(input string tag, input logic acc, input logic [1:0] rsn,
                            input logic [15:0] hd, input logic [6:0] c);
      check({tag, "_accepted"}, {31'b0, res_accepted}, {31'b0, acc});
      check({tag, "_reason"}, {30'b0, res_reason}, {30'b0, rsn});
      check({tag, "_headroom"}, {16'b0, res_headroom}, {16'b0, hd});
      check({tag, "_client"}, {25'b0, res_client}, {25'b0, c});
   endtask
   task automatic push(input logic [6:0] c, input logic [15:0] q, input logic sm);
      in_client = c; in_qty = q; in_set_max = sm; in_valid = 1;
      for (int k = 0; k < 100 && !in_ready; k++) begin @(posedge clk); #1; end
      if (!in_ready) begin
         vectors++; miscompares++;
         $display("FAIL push_wait: in_ready stayed 0, required 1");
      end
      @(posedge clk); #1;
      in_valid = 0;
   endtask
   task automatic wait_res(output int lat);
      lat = 0;
      while (!res_valid && lat < 300) begin @(posedge clk); #1; lat++; end
      if (!res_valid) begin
         vectors++; miscompares++;
         $display("FAIL res_wait: res_valid stayed 0, required 1");
      end
   endtask
   task automatic run_req(input logic [6:0] c, input logic [15:0] q, input logic sm,
                          output int lat, output int wr);
      int r0;
      r0 = rw_rises;
      push(c, q, sm);
      wait_res(lat);
      wr = rw_rises - r0;
   endtask
   task automatic consume(input int dly);
      repeat (dly) begin @(posedge clk); #1; end
      res_ready = 1;
      @(posedge clk); #1;
      res_ready = 0;
   endtask
   task automatic rand_req(output logic [6:0] c, output logic [15:0] q, output logic sm);
      int sel;
      sel = $urandom_range(0, 9);
      c  = sel < 4 ? 7'(sel) : sel < 8 ? 7'd5 : 7'($urandom_range(121, 127));
      sm = $urandom_range(0, 4) == 0;
      if (sm) q = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 2)) : 16'($urandom_range(2, 'h200));
      else q = $urandom_range(0, 3) == 0 ? 16'h0 : 16'($urandom_range(1, 'h80));
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int lat, wr;
      bit seen;
      logic [6:0] c;
      logic [15:0] q, ehd;
      logic sm, eacc, ewr;
      logic [1:0] ersn;
      tbl[0]  = '{7'd5,   16'h0100, 1'b1, 1'b1, RSN_OK,     16'h0000, 1'b1};
      tbl[1]  = '{7'd5,   16'h0010, 1'b0, 1'b1, RSN_OK,     16'h00F0, 1'b1};
      tbl[2]  = '{7'd5,   16'h0020, 1'b0, 1'b1, RSN_OK,     16'h00D0, 1'b1};
      tbl[3]  = '{7'd5,   16'h00C0, 1'b0, 1'b1, RSN_OK,     16'h0010, 1'b1};
      tbl[4]  = '{7'd5,   16'h0020, 1'b0, 1'b0, RSN_LIMIT,  16'h0010, 1'b0};
      tbl[5]  = '{7'd7,   16'h0200, 1'b1, 1'b1, RSN_OK,     16'h0000, 1'b1};
      tbl[6]  = '{7'd7,   16'h0001, 1'b1, 1'b0, RSN_BADREQ, 16'h0000, 1'b0};
      tbl[7]  = '{7'd122, 16'h0005, 1'b0, 1'b0, RSN_BADREQ, 16'h0000, 1'b0};
      tbl[8]  = '{7'd5,   16'h0000, 1'b0, 1'b1, RSN_OK,     16'h0010, 1'b0};
      tbl[9]  = '{7'd5,   16'h0010, 1'b0, 1'b1, RSN_OK,     16'h0000, 1'b1};
      tbl[10] = '{7'd5,   16'h0001, 1'b0, 1'b0, RSN_LIMIT,  16'h0000, 1'b0};
      tbl[11] = '{7'd7,   16'h0002, 1'b1, 1'b1, RSN_OK,     16'h0000, 1'b1};
      tbl[12] = '{7'd127, 16'h0300, 1'b1, 1'b0, RSN_BADREQ, 16'h0000, 1'b0};
      tbl[13] = '{7'd121, 16'hFFFF, 1'b1, 1'b1, RSN_OK,     16'h0000, 1'b1};
      tbl[14] = '{7'd121, 16'hFFFF, 1'b0, 1'b1, RSN_OK,     16'h0000, 1'b1};
      tbl[15] = '{7'd121, 16'h0001, 1'b0, 1'b0, RSN_LIMIT,  16'h0000, 1'b0};
      tbl[16] = '{7'd5,   16'h0008, 1'b1, 1'b1, RSN_OK,     16'h0000, 1'b1};
      tbl[17] = '{7'd5,   16'h0000, 1'b0, 1'b1, RSN_OK,     16'hFF08, 1'b0};
      tbl[18] = '{7'd5,   16'h0001, 1'b0, 1'b0, RSN_LIMIT,  16'hFF08, 1'b0};
      repeat (3) begin @(posedge clk); #1; end
      check("rst_in_ready", {31'b0, in_ready}, 1);
      check("rst_res_valid", {31'b0, res_valid}, 0);
      check("rst_mem_rw", {31'b0, mem_rw}, 0);
      check("rst_change_max", {31'b0, mem_change_max}, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_rdindex", {25'b0, mem_rdindex}, 0);
      check_res("rst", 1'b0, RSN_OK, 16'h0, 7'd0);
      rst = 0;
      @(posedge clk); #1;
      foreach (tbl[i]) begin
         run_req(tbl[i].c, tbl[i].q, tbl[i].sm, lat, wr);
         check_res($sformatf("v%0d", i), tbl[i].acc, tbl[i].rsn, tbl[i].hd, tbl[i].c);
         check($sformatf("v%0d_writes", i), wr, {31'b0, tbl[i].wr});
         check($sformatf("v%0d_latency", i), lat, tbl[i].wr ? 7 : 3);
         if (tbl[i].wr) begin
            check($sformatf("v%0d_wdata", i), last_wdata, tbl[i].sm ? {tbl[i].q, 16'h0} : {16'h0, tbl[i].q});
            check($sformatf("v%0d_change_max", i), {31'b0, last_cm}, {31'b0, tbl[i].sm});
         end
         model(tbl[i].c, tbl[i].q, tbl[i].sm, eacc, ersn, ehd, ewr);
         consume(0);
      end
      // written level already high when WRITE starts
      stale = 1;
      @(posedge clk); #1;
      model(7'd9, 16'h0040, 1'b1, eacc, ersn, ehd, ewr);
      run_req(7'd9, 16'h0040, 1'b1, lat, wr);
      check_res("stale", eacc, ersn, ehd, 7'd9);
      check("stale_latency", lat, 6);
      consume(0);
      stale = 0;
      repeat (2) begin @(posedge clk); #1; end
      // backpressure: five pushes with results stalled
      for (int i = 0; i < 5; i++) begin
         rand_req(c, q, sm);
         bq[i].c = c;
         model(c, q, sm, bq[i].acc, bq[i].rsn, bq[i].hd, bq[i].wr);
         push(c, q, sm);
      end
      check("bp_in_ready_full", {31'b0, in_ready}, 0);
      in_client = 7'd3; in_qty = 16'h1; in_set_max = 0; in_valid = 1;
      repeat (3) begin @(posedge clk); #1; end
      check("bp_in_ready_held", {31'b0, in_ready}, 0);
      in_valid = 0;
      for (int i = 0; i < 5; i++) begin
         wait_res(lat);
         check_res($sformatf("bp%0d", i), bq[i].acc, bq[i].rsn, bq[i].hd, bq[i].c);
         consume($urandom_range(0, 1));
      end
      seen = 0;
      repeat (10) begin @(posedge clk); #1; if (res_valid) seen = 1; end
      check("bp_no_extra_result", {31'b0, seen}, 0);
      for (int i = 0; i < 80; i++) begin
         rand_req(c, q, sm);
         model(c, q, sm, eacc, ersn, ehd, ewr);
         run_req(c, q, sm, lat, wr);
         check_res($sformatf("r%0d", i), eacc, ersn, ehd, c);
         check($sformatf("r%0d_writes", i), wr, {31'b0, ewr});
         check($sformatf("r%0d_latency", i), lat, ewr ? 7 : 3);
         consume($urandom_range(0, 2));
      end
      // write that never completes
      hold = 1;
      run_req(7'd9, 16'h0050, 1'b1, lat, wr);
      check_res("tmo", 1'b0, RSN_TIMEOUT, 16'h0, 7'd9);
      check("tmo_writes", wr, 1);
      check("tmo_latency", lat, 19);
      check("tmo_rw_low", {31'b0, mem_rw}, 0);
      consume(0);
      // reset during a write with another request queued
      push(7'd9, 16'h0060, 1'b1);
      push(7'd9, 16'h0070, 1'b1);
      for (int k = 0; k < 50 && !mem_rw; k++) begin @(posedge clk); #1; end
      check("rst_mid_rw_high", {31'b0, mem_rw}, 1);
      #2 rst = 1;
      #1 check("rst_mid_rw_drop", {31'b0, mem_rw}, 0);
      @(posedge clk); #1;
      rst = 0; hold = 0; res_ready = 1; seen = 0;
      repeat (30) begin @(posedge clk); #1; if (res_valid) seen = 1; end
      res_ready = 0;
      check("rst_mid_no_result", {31'b0, seen}, 0);
      check("rst_mid_in_ready", {31'b0, in_ready}, 1);
      check("rst_mid_no_write", {16'b0, mmax[9]}, 32'h40);
      model(7'd5, 16'h0000, 1'b0, eacc, ersn, ehd, ewr);
      run_req(7'd5, 16'h0000, 1'b0, lat, wr);
      check_res("post_rst", eacc, ersn, ehd, 7'd5);
      consume(0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
